mux_scan_n: RTL

//  Time-multiplexed N-channel scanner for BITS-wide data (7-segment patterns by default).

---
 rtl/mux_scan_n.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mux_scan_n.sv
// Time-multiplexed N-channel display scanner: auto scan with blanking gaps between
// channels, or a fixed manually selected channel, with one-hot digit enables.
module mux_scan_n #(
    parameter int BITS      = 7,
    parameter int CHANNELS  = 4,
    parameter int PERIOD    = 50000,
    parameter int BLANK_CYC = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     modo,
    input  logic [SEL_W-1:0]         sel_manual,
    input  logic [CHANNELS*BITS-1:0] D,
    output logic [BITS-1:0]          mux_out,
    output logic [SEL_W-1:0]         sel_out,
    output logic [CHANNELS-1:0]      ativo,
    output logic                     fim_ciclo
);

    localparam int MAX_CNT = (PERIOD > BLANK_CYC) ? PERIOD : BLANK_CYC;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic {
        SHOW,
        BLANK
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BITS-1:0]     mux_out_q, mux_out_d;
    logic [SEL_W-1:0]    sel_out_q, sel_out_d;
    logic [CHANNELS-1:0] ativo_q, ativo_d;
    logic                fim_ciclo_q, fim_ciclo_d;

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return int'(idx) < CHANNELS;
    endfunction

    function automatic logic [BITS-1:0] chan_data(input logic [SEL_W-1:0] idx);
        return D[int'(idx)*BITS +: BITS];
    endfunction

    // Out-of-range manual selections show as blank rather than indexing past D.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        mux_out_d   = mux_out_q;
        sel_out_d   = sel_out_q;
        ativo_d     = ativo_q;
        fim_ciclo_d = 1'b0;

        if (!enable) begin
            fim_ciclo_d = 1'b0;
        end else if (modo) begin
            state_d   = SHOW;
            cnt_d     = '0;
            sel_d     = sel_manual;
            sel_out_d = sel_manual;
            if (in_range(sel_manual)) begin
                mux_out_d = chan_data(sel_manual);
                ativo_d   = CHANNELS'(1) << sel_manual;
            end else begin
                mux_out_d = '1;
                ativo_d   = '0;
            end
        end else if (!in_range(sel_q)) begin
            state_d   = SHOW;
            cnt_d     = '0;
            sel_d     = '0;
            sel_out_d = sel_q;
            mux_out_d = '1;
            ativo_d   = '0;
        end else begin
            sel_out_d = sel_q;
            // sel_out lags sel by one cycle, so this flags the cycle it leaves the last channel.
            fim_ciclo_d = (sel_q == '0) && (sel_out_q == LAST_SEL);
            case (state_q)
                SHOW: begin
                    mux_out_d = chan_data(sel_q);
                    ativo_d   = CHANNELS'(1) << sel_q;
                    if (cnt_q == PERIOD_END) begin
                        cnt_d   = '0;
                        sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
                        state_d = (BLANK_CYC > 0) ? BLANK : SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BLANK: begin
                    mux_out_d = '1;
                    ativo_d   = '0;
                    if (cnt_q == BLANK_END) begin
                        cnt_d   = '0;
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SHOW;
            sel_q       <= '0;
            cnt_q       <= '0;
            mux_out_q   <= '1;
            sel_out_q   <= '0;
            ativo_q     <= '0;
            fim_ciclo_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            mux_out_q   <= mux_out_d;
            sel_out_q   <= sel_out_d;
            ativo_q     <= ativo_d;
            fim_ciclo_q <= fim_ciclo_d;
        end
    end

    assign mux_out   = mux_out_q;
    assign sel_out   = sel_out_q;
    assign ativo     = ativo_q;
    assign fim_ciclo = fim_ciclo_q;

endmodule
